// File: rtl/native_bus_arbiter.sv
// native_bus_arbiter: merges the core's instruction-side (i_) and data-side (d_)
// native valid/ready buses onto one shared native memory port.
//   - Read-address and write channels are arbitrated independently.
//   - An owner FIFO (0=i, 1=d) steers in-order read data back to its requester.
//   - proto_err is a sticky flag for read data arriving with no read outstanding.
// Ports:
//   clk, rst (asynchronous, active-low)
//   i_/d_ raddr/rdata : per-master read channels
//   i_/d_ waddr/wdata : per-master write channels
//   mem_*             : shared memory-side channels
//   proto_err         : sticky protocol error
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (d over i) on
// both read and write arbitration instead of round-robin.
module native_bus_arbiter #(
  parameter int unsigned bus_width   = 32,
  parameter int unsigned outstanding = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_raddr_valid,
  input  logic [bus_width-1:0] i_raddr,
  output logic                 i_raddr_ready,
  output logic                 i_rdata_valid,
  output logic [bus_width-1:0] i_rdata,
  input  logic                 i_rdata_ready,
  input  logic                 i_waddr_valid,
  input  logic [bus_width-1:0] i_waddr,
  output logic                 i_waddr_ready,
  input  logic                 i_wdata_valid,
  input  logic [bus_width-1:0] i_wdata,
  output logic                 i_wdata_ready,
  input  logic                 d_raddr_valid,
  input  logic [bus_width-1:0] d_raddr,
  output logic                 d_raddr_ready,
  output logic                 d_rdata_valid,
  output logic [bus_width-1:0] d_rdata,
  input  logic                 d_rdata_ready,
  input  logic                 d_waddr_valid,
  input  logic [bus_width-1:0] d_waddr,
  output logic                 d_waddr_ready,
  input  logic                 d_wdata_valid,
  input  logic [bus_width-1:0] d_wdata,
  output logic                 d_wdata_ready,
  output logic                 mem_raddr_valid,
  output logic [bus_width-1:0] mem_raddr,
  input  logic                 mem_raddr_ready,
  input  logic                 mem_rdata_valid,
  input  logic [bus_width-1:0] mem_rdata,
  output logic                 mem_rdata_ready,
  output logic                 mem_waddr_valid,
  output logic [bus_width-1:0] mem_waddr,
  input  logic                 mem_waddr_ready,
  output logic                 mem_wdata_valid,
  output logic [bus_width-1:0] mem_wdata,
  input  logic                 mem_wdata_ready,
  output logic                 proto_err
);

  localparam int unsigned PTR_W = (outstanding > 1) ? $clog2(outstanding) : 1;
  localparam int unsigned CNT_W = $clog2(outstanding + 1);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_BUSY = 1'b1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(outstanding - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Owner FIFO and read-address lock state
  logic [outstanding-1:0] owner_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   r_lock_q, r_lock_id_q;

  // Write FSM state
  logic [0:0] w_state_q, w_state_d;
  logic       w_owner_q, w_owner_d;
  logic       aw_done_q, aw_done_d;
  logic       wd_done_q, wd_done_d;
  logic       w_take;

  logic fifo_full, fifo_empty, head;
  logic r_pick, r_gnt_id, r_sel_valid, r_hs, pop;
  logic w_req_i, w_req_d, w_pick;

  assign fifo_full  = (count_q == CNT_W'(outstanding));
  assign fifo_empty = (count_q == '0);
  assign head       = owner_q[rd_ptr_q];
  assign w_req_i    = i_waddr_valid | i_wdata_valid;
  assign w_req_d    = d_waddr_valid | d_wdata_valid;

`ifdef ARB_FIXED_PRIORITY_EN
  assign r_pick = d_raddr_valid;
  assign w_pick = w_req_d;
`else
  // Round-robin preference (1 = d favoured); the last winner loses ties
  logic r_pref_q, w_pref_q;

  assign r_pick = (i_raddr_valid && d_raddr_valid) ? r_pref_q : d_raddr_valid;
  assign w_pick = (w_req_i && w_req_d) ? w_pref_q : w_req_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pref_q <= 1'b1;
      w_pref_q <= 1'b1;
    end else begin
      if (r_hs)   r_pref_q <= ~r_gnt_id;
      if (w_take) w_pref_q <= ~w_pick;
    end
  end
`endif

  // Read address: a stalled request keeps its grant so the address stays stable
  assign r_gnt_id        = r_lock_q ? r_lock_id_q : r_pick;
  assign r_sel_valid     = r_gnt_id ? d_raddr_valid : i_raddr_valid;
  assign mem_raddr_valid = rst && !fifo_full && r_sel_valid;
  assign mem_raddr       = r_gnt_id ? d_raddr : i_raddr;
  assign i_raddr_ready   = mem_raddr_valid && !r_gnt_id && mem_raddr_ready;
  assign d_raddr_ready   = mem_raddr_valid &&  r_gnt_id && mem_raddr_ready;
  assign r_hs            = mem_raddr_valid && mem_raddr_ready;

  // Read data: FIFO head picks the destination; stray data is sunk when empty
  assign i_rdata_valid   = rst && !fifo_empty && !head && mem_rdata_valid;
  assign d_rdata_valid   = rst && !fifo_empty &&  head && mem_rdata_valid;
  assign i_rdata         = (!fifo_empty && !head) ? mem_rdata : '0;
  assign d_rdata         = (!fifo_empty &&  head) ? mem_rdata : '0;
  assign mem_rdata_ready = rst && (fifo_empty || (head ? d_rdata_ready : i_rdata_ready));
  assign pop             = mem_rdata_valid && mem_rdata_ready && !fifo_empty;

  // Owner FIFO, read lock and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_lock_q    <= 1'b0;
      r_lock_id_q <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (r_hs) begin
        owner_q[wr_ptr_q] <= r_gnt_id;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({r_hs, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      r_lock_q    <= mem_raddr_valid && !mem_raddr_ready;
      r_lock_id_q <= r_gnt_id;
      if (mem_rdata_valid && fifo_empty) proto_err <= 1'b1;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_owner_q <= 1'b0;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_owner_q <= w_owner_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
    end
  end

  // Write FSM next state and channel routing; a finished channel is masked off
  always_comb begin
    w_state_d       = w_state_q;
    w_owner_d       = w_owner_q;
    aw_done_d       = aw_done_q;
    wd_done_d       = wd_done_q;
    w_take          = 1'b0;
    mem_waddr_valid = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_waddr       = w_owner_q ? d_waddr : i_waddr;
    mem_wdata       = w_owner_q ? d_wdata : i_wdata;
    i_waddr_ready   = 1'b0;
    i_wdata_ready   = 1'b0;
    d_waddr_ready   = 1'b0;
    d_wdata_ready   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (w_req_i || w_req_d) begin
          w_take    = 1'b1;
          w_owner_d = w_pick;
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        mem_waddr_valid = !aw_done_q && (w_owner_q ? d_waddr_valid : i_waddr_valid);
        mem_wdata_valid = !wd_done_q && (w_owner_q ? d_wdata_valid : i_wdata_valid);
        i_waddr_ready   = !w_owner_q && mem_waddr_valid && mem_waddr_ready;
        i_wdata_ready   = !w_owner_q && mem_wdata_valid && mem_wdata_ready;
        d_waddr_ready   =  w_owner_q && mem_waddr_valid && mem_waddr_ready;
        d_wdata_ready   =  w_owner_q && mem_wdata_valid && mem_wdata_ready;
        aw_done_d       = aw_done_q || (mem_waddr_valid && mem_waddr_ready);
        wd_done_d       = wd_done_q || (mem_wdata_valid && mem_wdata_ready);
        if (aw_done_d && wd_done_d) begin
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_native_bus_arbiter.sv
module tb_native_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_raddr_valid, d_raddr_valid, i_raddr_ready, d_raddr_ready;
  logic [31:0] i_raddr, d_raddr;
  logic        i_rdata_valid, d_rdata_valid, i_rdata_ready, d_rdata_ready;
  logic [31:0] i_rdata, d_rdata;
  logic        i_waddr_valid, i_wdata_valid, i_waddr_ready, i_wdata_ready;
  logic        d_waddr_valid, d_wdata_valid, d_waddr_ready, d_wdata_ready;
  logic [31:0] i_waddr, i_wdata, d_waddr, d_wdata;
  logic        mem_raddr_valid, mem_raddr_ready, mem_rdata_valid, mem_rdata_ready;
  logic        mem_waddr_valid, mem_waddr_ready, mem_wdata_valid, mem_wdata_ready;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  native_bus_arbiter #(.bus_width(32), .outstanding(2)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr(i_raddr), .i_raddr_ready(i_raddr_ready),
    .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata), .i_rdata_ready(i_rdata_ready),
    .i_waddr_valid(i_waddr_valid), .i_waddr(i_waddr), .i_waddr_ready(i_waddr_ready),
    .i_wdata_valid(i_wdata_valid), .i_wdata(i_wdata), .i_wdata_ready(i_wdata_ready),
    .d_raddr_valid(d_raddr_valid), .d_raddr(d_raddr), .d_raddr_ready(d_raddr_ready),
    .d_rdata_valid(d_rdata_valid), .d_rdata(d_rdata), .d_rdata_ready(d_rdata_ready),
    .d_waddr_valid(d_waddr_valid), .d_waddr(d_waddr), .d_waddr_ready(d_waddr_ready),
    .d_wdata_valid(d_wdata_valid), .d_wdata(d_wdata), .d_wdata_ready(d_wdata_ready),
    .mem_raddr_valid(mem_raddr_valid), .mem_raddr(mem_raddr), .mem_raddr_ready(mem_raddr_ready),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready),
    .mem_waddr_valid(mem_waddr_valid), .mem_waddr(mem_waddr), .mem_waddr_ready(mem_waddr_ready),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
    .proto_err(proto_err)
  );

  // One read-path cycle: stimulus and the outputs it must produce before the edge
  typedef struct {
    logic [5:0]  in;     // {i_rv, d_rv, mem_raddr_ready, i_rdr, d_rdr, mem_rdata_valid}
    logic [31:0] md;
    logic [2:0]  ra;     // {i_raddr_ready, d_raddr_ready, mem_raddr_valid}
    logic [31:0] mra;    // checked when mem_raddr_valid expected
    logic [1:0]  rd;     // {i_rdata_valid, d_rdata_valid}
    logic [31:0] rdata;  // checked on whichever rdata_valid is expected
    logic [1:0]  mrdr;   // 0/1 expected mem_rdata_ready, 2 = not checked
    logic        perr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] md,
                              input logic [2:0] ra, input logic [31:0] mra,
                              input logic [1:0] rd, input logic [31:0] rdata,
                              input logic [1:0] mrdr, input logic perr);
    vec_t v;
    v.in = in; v.md = md; v.ra = ra; v.mra = mra;
    v.rd = rd; v.rdata = rdata; v.mrdr = mrdr; v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wexp(input string tag, input logic [1:0] mv, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [1:0] ir, input logic [1:0] dr);
    chk({tag, ".mem_wvalids"}, 32'({mem_waddr_valid, mem_wdata_valid}), 32'(mv));
    if (mv[1]) chk({tag, ".mem_waddr"}, mem_waddr, wa);
    if (mv[0]) chk({tag, ".mem_wdata"}, mem_wdata, wd);
    chk({tag, ".i_wreadies"}, 32'({i_waddr_ready, i_wdata_ready}), 32'(ir));
    chk({tag, ".d_wreadies"}, 32'({d_waddr_ready, d_wdata_ready}), 32'(dr));
  endtask

  task automatic wdrive(input logic dv, input logic iv, input logic mwr);
    d_waddr_valid = dv; d_wdata_valid = dv;
    i_waddr_valid = iv; i_wdata_valid = iv;
    mem_wdata_ready = mwr;
  endtask

  initial begin
    // Read-path table, applied in order from reset
    vecs[0]  = mk(6'b111110, 32'h0,    3'b011, 32'h100, 2'b00, 32'h0,    2'd2, 1'b0);
    vecs[1]  = mk(6'b111110, 32'h0,    3'b101, 32'h0,   2'b00, 32'h0,    2'd1, 1'b0);
    vecs[2]  = mk(6'b101111, 32'hAAAA, 3'b000, 32'h0,   2'b01, 32'hAAAA, 2'd1, 1'b0);
    vecs[3]  = mk(6'b101111, 32'hBBBB, 3'b101, 32'h0,   2'b10, 32'hBBBB, 2'd1, 1'b0);
    vecs[4]  = mk(6'b001010, 32'h0,    3'b000, 32'h0,   2'b00, 32'h0,    2'd0, 1'b0);
    vecs[5]  = mk(6'b001011, 32'hCCCC, 3'b000, 32'h0,   2'b10, 32'hCCCC, 2'd0, 1'b0);
    vecs[6]  = mk(6'b001111, 32'hCCCC, 3'b000, 32'h0,   2'b10, 32'hCCCC, 2'd1, 1'b0);
    vecs[7]  = mk(6'b100110, 32'h0,    3'b001, 32'h0,   2'b00, 32'h0,    2'd2, 1'b0);
    vecs[8]  = mk(6'b110110, 32'h0,    3'b001, 32'h0,   2'b00, 32'h0,    2'd2, 1'b0);
    vecs[9]  = mk(6'b110110, 32'h0,    3'b001, 32'h0,   2'b00, 32'h0,    2'd2, 1'b0);
    vecs[10] = mk(6'b111110, 32'h0,    3'b101, 32'h0,   2'b00, 32'h0,    2'd2, 1'b0);
    vecs[11] = mk(6'b011110, 32'h0,    3'b011, 32'h100, 2'b00, 32'h0,    2'd1, 1'b0);
    vecs[12] = mk(6'b001111, 32'hDDDD, 3'b000, 32'h0,   2'b10, 32'hDDDD, 2'd1, 1'b0);
    vecs[13] = mk(6'b001111, 32'hEEEE, 3'b000, 32'h0,   2'b01, 32'hEEEE, 2'd1, 1'b0);
    vecs[14] = mk(6'b001111, 32'hFFFF, 3'b000, 32'h0,   2'b00, 32'h0,    2'd1, 1'b0);
    vecs[15] = mk(6'b001110, 32'h0,    3'b000, 32'h0,   2'b00, 32'h0,    2'd2, 1'b1);
    vecs[16] = mk(6'b101110, 32'h0,    3'b101, 32'h0,   2'b00, 32'h0,    2'd2, 1'b1);

    rst = 1'b0;
    i_raddr = 32'h0; d_raddr = 32'h100; mem_rdata = 32'h0;
    i_waddr = 32'h300; i_wdata = 32'h1234; d_waddr = 32'h200; d_wdata = 32'hDEAD;
    i_raddr_valid = 1'b1; d_raddr_valid = 1'b1; mem_raddr_ready = 1'b1;
    i_rdata_ready = 1'b1; d_rdata_ready = 1'b1; mem_rdata_valid = 1'b1;
    i_waddr_valid = 1'b1; i_wdata_valid = 1'b1; d_waddr_valid = 1'b1; d_wdata_valid = 1'b1;
    mem_waddr_ready = 1'b1; mem_wdata_ready = 1'b1;

    // Reset: every handshake output low despite active inputs
    #1;
    chk("rst.mem_raddr_valid", 32'(mem_raddr_valid), 32'd0);
    chk("rst.raddr_ready", 32'({i_raddr_ready, d_raddr_ready}), 32'd0);
    chk("rst.rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'd0);
    chk("rst.mem_rdata_ready", 32'(mem_rdata_ready), 32'd0);
    wexp("rst", 2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    chk("rst.proto_err", 32'(proto_err), 32'd0);

    i_raddr_valid = 1'b0; d_raddr_valid = 1'b0; mem_rdata_valid = 1'b0;
    wdrive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 17; k++) begin
      {i_raddr_valid, d_raddr_valid, mem_raddr_ready,
       i_rdata_ready, d_rdata_ready, mem_rdata_valid} = vecs[k].in;
      mem_rdata = vecs[k].md;
      #1;
      chk($sformatf("v%0d.raddr", k),
          32'({i_raddr_ready, d_raddr_ready, mem_raddr_valid}), 32'(vecs[k].ra));
      if (vecs[k].ra[0]) chk($sformatf("v%0d.mem_raddr", k), mem_raddr, vecs[k].mra);
      chk($sformatf("v%0d.rdata_valid", k),
          32'({i_rdata_valid, d_rdata_valid}), 32'(vecs[k].rd));
      if (vecs[k].rd[1]) chk($sformatf("v%0d.i_rdata", k), i_rdata, vecs[k].rdata);
      if (vecs[k].rd[0]) chk($sformatf("v%0d.d_rdata", k), d_rdata, vecs[k].rdata);
      if (vecs[k].mrdr != 2'd2)
        chk($sformatf("v%0d.mem_rdata_ready", k), 32'(mem_rdata_ready), 32'(vecs[k].mrdr[0]));
      chk($sformatf("v%0d.proto_err", k), 32'(proto_err), 32'(vecs[k].perr));
      tick();
    end
    i_raddr_valid = 1'b0; d_raddr_valid = 1'b0; mem_rdata_valid = 1'b0;

    // d write with wdata two cycles after waddr, i write pending throughout
    mem_waddr_ready = 1'b1;
    wdrive(1'b1, 1'b1, 1'b0); #1; wexp("w0", 2'b00, 32'h0,   32'h0,    2'b00, 2'b00); tick();
    wdrive(1'b1, 1'b1, 1'b0); #1; wexp("w1", 2'b11, 32'h200, 32'hDEAD, 2'b00, 2'b10); tick();
    wdrive(1'b1, 1'b1, 1'b0); #1; wexp("w2", 2'b01, 32'h0,   32'hDEAD, 2'b00, 2'b00); tick();
    wdrive(1'b1, 1'b1, 1'b1); #1; wexp("w3", 2'b01, 32'h0,   32'hDEAD, 2'b00, 2'b01); tick();
    wdrive(1'b0, 1'b1, 1'b1); #1; wexp("w4", 2'b00, 32'h0,   32'h0,    2'b00, 2'b00); tick();
    wdrive(1'b0, 1'b1, 1'b1); #1; wexp("w5", 2'b11, 32'h300, 32'h1234, 2'b11, 2'b00); tick();
    wdrive(1'b0, 1'b0, 1'b1); #1; wexp("w6", 2'b00, 32'h0,   32'h0,    2'b00, 2'b00); tick();

    // Reset mid-operation with two reads outstanding
    i_raddr_valid = 1'b1; mem_raddr_ready = 1'b1; i_rdata_ready = 1'b1;
    #1;
    chk("mid.second_read_ready", 32'(i_raddr_ready), 32'd1);
    tick();
    mem_rdata_valid = 1'b1; mem_rdata = 32'h7777;
    #1;
    chk("mid.full_ready", 32'(i_raddr_ready), 32'd0);
    chk("mid.pre_rdata_valid", 32'(i_rdata_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid.rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'd0);
    chk("mid.mem_rdata_ready", 32'(mem_rdata_ready), 32'd0);
    chk("mid.raddr", 32'({i_raddr_ready, d_raddr_ready, mem_raddr_valid}), 32'd0);
    chk("mid.proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rdata_valid = 1'b0; i_raddr = 32'h10;
    #1;
    chk("post.raddr", 32'({i_raddr_ready, d_raddr_ready, mem_raddr_valid}), 32'b101);
    chk("post.mem_raddr", mem_raddr, 32'h10);
    tick();
    i_raddr_valid = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h5555;
    #1;
    chk("post.rdata_valid", 32'({i_rdata_valid, d_rdata_valid}), 32'b10);
    chk("post.i_rdata", i_rdata, 32'h5555);
    chk("post.mem_rdata_ready", 32'(mem_rdata_ready), 32'd1);
    tick();
    mem_rdata_valid = 1'b0;
    #1;
    chk("post.proto_err", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
